// File: rtl/io64_uart_tx.sv
// Serialises every change of the cpu15 port-64 output as two 8N1 UART frames
// (high byte, then low byte), buffering up to FIFO_DEPTH words.
module io64_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] IO64_OUT,
  output logic        TX,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [2:0]  FIFO_LEVEL
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] BAUD_RELOAD = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] FULL_LEVEL  = 3'(FIFO_DEPTH);

  logic [15:0] last_q;
  logic [15:0] mem [FIFO_DEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  level;

  state_t      state;
  logic        byte_sel;
  logic [2:0]  bit_cnt;
  logic [7:0]  baud_cnt;
  logic [15:0] word_q;

  logic        push;
  logic        pop;
  logic        accept;
  logic [7:0]  cur_byte;

  // A pop frees a slot on the same edge, so a push at full level is still accepted.
  always_comb begin
    push     = (IO64_OUT != last_q);
    pop      = (state == IDLE) && (level != 3'd0);
    accept   = push && ((level != FULL_LEVEL) || pop);
    cur_byte = byte_sel ? word_q[7:0] : word_q[15:8];
  end

  // NOTE: the storage array has no reset; clearing the pointers and level
  // already makes any stale contents unreachable.
  always_ff @(posedge CLK) begin
    if (accept) mem[wr_ptr] <= IO64_OUT;
  end

  // NOTE: every register below uses non-blocking assignments so all state
  // updates see the pre-edge values, matching the hardware behaviour.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_q  <= 16'h0000;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      level   <= 3'd0;
      OVERRUN <= 1'b0;
    end else begin
      last_q <= IO64_OUT;
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      case ({accept, pop})
        2'b10:   level <= level + 3'd1;
        2'b01:   level <= level - 3'd1;
        default: level <= level;
      endcase
      if (push && !accept) OVERRUN <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      TX       <= 1'b1;
      byte_sel <= 1'b0;
      bit_cnt  <= 3'd0;
      baud_cnt <= 8'd0;
      word_q   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          TX       <= 1'b1;
          baud_cnt <= 8'd0;
          if (pop) begin
            word_q   <= mem[rd_ptr];
            byte_sel <= 1'b0;
            state    <= START;
            TX       <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
          end
        end

        START: begin
          if (baud_cnt == 8'd0) begin
            state    <= DATA;
            bit_cnt  <= 3'd0;
            TX       <= cur_byte[0];
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end

        DATA: begin
          if (baud_cnt == 8'd0) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              TX      <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end

        STOP: begin
          if (baud_cnt == 8'd0) begin
            // Low byte follows the high byte with no idle gap.
            if (!byte_sel) begin
              byte_sel <= 1'b1;
              state    <= START;
              TX       <= 1'b0;
              baud_cnt <= BAUD_RELOAD;
            end else begin
              state <= IDLE;
              TX    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY       = (state != IDLE) || (level != 3'd0);
  assign FIFO_LEVEL = level;

endmodule

// File: tb/tb_io64_uart_tx.sv
// Scoreboard bench for io64_uart_tx: stimulus queues expected words, a UART
// receiver process decodes TX and compares each received word.
module tb_io64_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] io;
  logic        tx;
  logic        busy;
  logic        ovr;
  logic [2:0]  lvl;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] sb[$];
  bit          rst_seen = 1'b0;

  io64_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK        (clk),
    .RESET      (rst),
    .IO64_OUT   (io),
    .TX         (tx),
    .BUSY       (busy),
    .OVERRUN    (ovr),
    .FIFO_LEVEL (lvl)
  );

  always #5 clk = ~clk;

  always @(posedge rst) rst_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] v);
    io = v;
    tick(1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  // UART receiver: samples mid-bit on falling clock edges, 20 bit slots per word.
  initial begin : monitor
    bit          rx_on;
    int          cyc;
    int          j;
    logic [19:0] bits;
    logic [15:0] word;
    logic [15:0] exp;
    rx_on = 1'b0;
    cyc   = 0;
    bits  = '0;
    forever begin
      @(negedge clk);
      if (rst || rst_seen) begin
        rx_on    = 1'b0;
        rst_seen = 1'b0;
      end else if (!rx_on) begin
        if (tx === 1'b0) begin
          rx_on = 1'b1;
          cyc   = 0;
        end
      end else begin
        cyc++;
        if (cyc >= 2 && ((cyc - 2) % CPB) == 0) begin
          j = (cyc - 2) / CPB;
          bits[j] = tx;
          if (j == 19) begin
            rx_on = 1'b0;
            for (int i = 0; i < 8; i++) begin
              word[8 + i] = bits[1 + i];
              word[i]     = bits[11 + i];
            end
            check("frame_bits", {bits[0], bits[9], bits[10], bits[19]}, 4'b0101);
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_word: got %h required none", word);
            end else begin
              exp = sb.pop_front();
              check("rx_word", word, exp);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int bad_cyc;
    rst = 1'b1;
    io  = 16'h0000;

    // Reset values, before any clock edge.
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_lvl", lvl, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    // Single word 0xA55A: latency and exact word duration.
    sb.push_back(16'hA55A);
    drive(16'hA55A);
    check("a55a_lvl_k", lvl, 3'd1);
    check("a55a_busy_k", busy, 1'b1);
    check("a55a_tx_k", tx, 1'b1);
    tick(1);
    check("a55a_tx_start", tx, 1'b0);
    check("a55a_lvl_k1", lvl, 3'd0);
    tick(CPB);
    check("a55a_bit0", tx, 1'b1);
    tick(75);
    check("a55a_busy_k80", busy, 1'b1);
    tick(1);
    check("a55a_busy_k81", busy, 1'b0);
    tick(3);

    // Constant input: one word, then silence.
    sb.push_back(16'h1234);
    drive(16'h1234);
    wait_idle(200);
    bad_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1 || busy !== 1'b0) bad_cyc++;
    end
    check("hold_quiet", bad_cyc, 0);

    // Burst 1..6: word 6 dropped, overrun set.
    for (int v = 1; v <= 5; v++) sb.push_back(16'(v));
    drive(16'd1);
    check("burst_lvl_k", lvl, 3'd1);
    drive(16'd2);
    check("burst_lvl_k1", lvl, 3'd1);
    check("burst_tx_k1", tx, 1'b0);
    drive(16'd3);
    drive(16'd4);
    drive(16'd5);
    check("burst_lvl_full", lvl, 3'd4);
    check("burst_ovr_before", ovr, 1'b0);
    drive(16'd6);
    check("burst_lvl_drop", lvl, 3'd4);
    check("burst_ovr_set", ovr, 1'b1);
    wait_idle(600);
    check("burst_ovr_sticky", ovr, 1'b1);
    tick(3);

    // Same burst, reset during DATA of word 3 with 6 held on the input.
    for (int v = 1; v <= 5; v++) sb.push_back(16'(v));
    for (int v = 1; v <= 6; v++) drive(16'(v));
    tick(170);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #2;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ovr", ovr, 1'b0);
    check("mid_rst_lvl", lvl, 3'd0);
    sb.delete();
    #4;
    rst = 1'b0;
    sb.push_back(16'h0006);
    @(posedge clk);
    #1;
    check("post_rst_lvl", lvl, 3'd1);
    check("post_rst_ovr", ovr, 1'b0);
    wait_idle(200);
    tick(10);
    check("post_rst_ovr_end", ovr, 1'b0);

    // Push and pop on the same edge at full level.
    sb.push_back(16'h0101);
    sb.push_back(16'h0202);
    sb.push_back(16'h0303);
    sb.push_back(16'h0404);
    sb.push_back(16'h0505);
    sb.push_back(16'h0606);
    drive(16'h0101);
    drive(16'h0202);
    drive(16'h0303);
    drive(16'h0404);
    drive(16'h0505);
    check("pp_lvl_full", lvl, 3'd4);
    tick(77);
    check("pp_lvl_idle", lvl, 3'd4);
    check("pp_tx_gap", tx, 1'b1);
    drive(16'h0606);
    check("pp_lvl_same", lvl, 3'd4);
    check("pp_ovr", ovr, 1'b0);
    check("pp_tx_start", tx, 1'b0);
    wait_idle(700);
    tick(5);
    check("pp_ovr_end", ovr, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
